// File: rtl/audio_serial_core.sv
// Codec serial core: captures stereo ADC frames and plays stereo DAC frames from a small FIFO,
// in I2S (MODE 0) or left-justified (MODE 1) framing, with all codec clocks oversampled by clk.
module audio_serial_core #(
  parameter int SAMPLE_W = 24,
  parameter int DEPTH    = 4,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                adclrck,
  input  logic                adcdat,
  input  logic                daclrck,
  output logic                dacdat,
  output logic [SAMPLE_W-1:0] adc_left,
  output logic [SAMPLE_W-1:0] adc_right,
  output logic                adc_valid,
  input  logic [SAMPLE_W-1:0] dac_left,
  input  logic [SAMPLE_W-1:0] dac_right,
  input  logic                dac_valid,
  output logic                dac_ready,
  output logic [15:0]         dac_underrun_cnt
);

  localparam int AddrW = $clog2(DEPTH);
  localparam int CntW  = 6;
  localparam logic [CntW-1:0]  CntMax   = CntW'(SAMPLE_W + 1);
  localparam logic [CntW-1:0]  PosFirst = CntW'((MODE == 0) ? 1 : 0);
  localparam logic [CntW-1:0]  WordLen  = CntW'(SAMPLE_W);
  localparam logic [AddrW:0]   DepthC   = (AddrW + 1)'(DEPTH);

  // Synchronisers: [0],[1] are the 2-FF chain, [2] is the history flop.
  logic [2:0] bclk_sync_q, alr_sync_q, dlr_sync_q, adat_sync_q;

  always_ff @(posedge clk) begin
    bclk_sync_q <= {bclk_sync_q[1:0], bclk};
    alr_sync_q  <= {alr_sync_q[1:0], adclrck};
    dlr_sync_q  <= {dlr_sync_q[1:0], daclrck};
    adat_sync_q <= {adat_sync_q[1:0], adcdat};
  end

  logic b_rise, b_fall, alr_edge, alr_fall, dlr_edge, dlr_fall, dlr_level, adat;

  assign b_rise    = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign b_fall    = ~bclk_sync_q[1] & bclk_sync_q[2];
  assign alr_edge  = alr_sync_q[1] ^ alr_sync_q[2];
  assign alr_fall  = ~alr_sync_q[1] & alr_sync_q[2];
  assign dlr_edge  = dlr_sync_q[1] ^ dlr_sync_q[2];
  assign dlr_fall  = ~dlr_sync_q[1] & dlr_sync_q[2];
  assign dlr_level = dlr_sync_q[1];
  // Data is taken one stage later, i.e. the value held just before the bclk rise.
  assign adat      = adat_sync_q[2];

  // ---------------------------------------------------------------- ADC capture
  logic [CntW-1:0]     adc_cnt_q, adc_cnt_d, adc_rel;
  logic [SAMPLE_W-1:0] adc_sr_q, adc_sr_d;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic                left_ok_q, left_ok_d;
  logic                armed_q, armed_d;
  logic [SAMPLE_W-1:0] adc_left_q, adc_left_d, adc_right_q, adc_right_d;
  logic                adc_valid_q, adc_valid_d;
  logic                adc_full;

  // Slot-relative position; below PosFirst it wraps to a large value and is rejected.
  assign adc_rel  = adc_cnt_q - PosFirst;
  assign adc_full = (adc_cnt_q >= PosFirst + WordLen);

  always_comb begin
    adc_cnt_d   = adc_cnt_q;
    adc_sr_d    = adc_sr_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    armed_d     = armed_q;
    adc_left_d  = adc_left_q;
    adc_right_d = adc_right_q;
    adc_valid_d = 1'b0;
    if (alr_edge) begin
      adc_cnt_d = '0;
      adc_sr_d  = '0;
      if (alr_fall) begin
        if (armed_q && left_ok_q && adc_full) begin
          adc_left_d  = left_hold_q;
          adc_right_d = adc_sr_q;
          adc_valid_d = 1'b1;
        end
        armed_d   = 1'b1;
        left_ok_d = 1'b0;
      end else begin
        left_hold_d = adc_sr_q;
        left_ok_d   = armed_q && adc_full;
      end
    end else if (b_rise) begin
      if (adc_rel < WordLen) begin
        adc_sr_d = {adc_sr_q[SAMPLE_W-2:0], adat};
      end
      if (adc_cnt_q != CntMax) begin
        adc_cnt_d = adc_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_cnt_q   <= '0;
      adc_sr_q    <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      armed_q     <= 1'b0;
      adc_left_q  <= '0;
      adc_right_q <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      adc_cnt_q   <= adc_cnt_d;
      adc_sr_q    <= adc_sr_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      armed_q     <= armed_d;
      adc_left_q  <= adc_left_d;
      adc_right_q <= adc_right_d;
      adc_valid_q <= adc_valid_d;
    end
  end

  assign adc_left  = adc_left_q;
  assign adc_right = adc_right_q;
  assign adc_valid = adc_valid_q;

  // ---------------------------------------------------------------- DAC FIFO
  logic [SAMPLE_W-1:0] mem_l_q [DEPTH];
  logic [SAMPLE_W-1:0] mem_r_q [DEPTH];
  logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]      count_q, count_d;
  logic                ready_en_q;
  logic                push, pop;

  assign dac_ready = ready_en_q && (count_q < DepthC);
  assign push      = dac_valid && dac_ready;
  assign pop       = dlr_fall && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= dac_left;
      mem_r_q[wr_ptr_q] <= dac_right;
    end
  end

  // ---------------------------------------------------------------- DAC playout
  logic [CntW-1:0]     dac_cnt_q, dac_cnt_d, dac_pos, dac_rel;
  logic [SAMPLE_W-1:0] play_l_q, play_l_d, play_r_q, play_r_d;
  logic [SAMPLE_W-1:0] dac_word, dac_shift;
  logic                dacdat_q, dacdat_d;
  logic [15:0]         und_q, und_d;

  always_comb begin
    play_l_d  = play_l_q;
    play_r_d  = play_r_q;
    und_d     = und_q;
    dac_cnt_d = dac_cnt_q;
    dacdat_d  = dacdat_q;
    dac_pos   = '0;
    dac_rel   = '0;
    dac_word  = '0;
    dac_shift = '0;
    if (dlr_fall) begin
      if (count_q != '0) begin
        play_l_d = mem_l_q[rd_ptr_q];
        play_r_d = mem_r_q[rd_ptr_q];
      end else begin
        play_l_d = '0;
        play_r_d = '0;
        if (und_q != 16'hFFFF) begin
          und_d = und_q + 16'd1;
        end
      end
    end
    if (dlr_edge) begin
      dac_cnt_d = '0;
    end else if (b_rise && (dac_cnt_q != CntMax)) begin
      dac_cnt_d = dac_cnt_q + 1'b1;
    end
    // The bit driven now is sampled at the next bclk rise, i.e. slot position dac_pos.
    if (b_fall) begin
      dac_pos  = dlr_edge ? '0 : dac_cnt_q;
      dac_rel  = dac_pos - PosFirst;
      dac_word = dlr_level ? play_r_d : play_l_d;
      dacdat_d = 1'b0;
      if (dac_rel < WordLen) begin
        dac_shift = dac_word << dac_rel;
        dacdat_d  = dac_shift[SAMPLE_W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      dac_cnt_q  <= '0;
      play_l_q   <= '0;
      play_r_q   <= '0;
      dacdat_q   <= 1'b0;
      und_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
      dac_cnt_q  <= dac_cnt_d;
      play_l_q   <= play_l_d;
      play_r_q   <= play_r_d;
      dacdat_q   <= dacdat_d;
      und_q      <= und_d;
    end
  end

  assign dacdat           = dacdat_q;
  assign dac_underrun_cnt = und_q;

endmodule

// File: tb/tb_audio_serial_core.sv
// Directed bench: one I2S and one left-justified instance share the codec clocks and the
// DAC push port; serial streams are built and decoded by the bench from the framing rules.
module tb_audio_serial_core;

  logic        clk = 1'b0;
  logic        reset, bclk, lrck, adcdat0, adcdat1;
  logic        dacdat0, dacdat1, adc_valid0, adc_valid1, dac_ready0, dac_ready1;
  logic [23:0] adc_left0, adc_right0, adc_left1, adc_right1;
  logic [23:0] dac_left, dac_right;
  logic        dac_valid;
  logic [15:0] und0, und1;

  int vectors = 0;
  int miscompares = 0;
  int vc0 = 0;
  int vc1 = 0;
  logic [63:0] cap0, cap1;

  logic [23:0] al_t [0:16];
  logic [23:0] ar_t [0:16];
  logic [23:0] dl_t [0:16];
  logic [23:0] dr_t [0:16];

  always #5 clk = ~clk;

  audio_serial_core #(.SAMPLE_W(24), .DEPTH(4), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .bclk(bclk), .adclrck(lrck), .adcdat(adcdat0), .daclrck(lrck),
    .dacdat(dacdat0), .adc_left(adc_left0), .adc_right(adc_right0), .adc_valid(adc_valid0),
    .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid), .dac_ready(dac_ready0),
    .dac_underrun_cnt(und0)
  );

  audio_serial_core #(.SAMPLE_W(24), .DEPTH(4), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .bclk(bclk), .adclrck(lrck), .adcdat(adcdat1), .daclrck(lrck),
    .dacdat(dacdat1), .adc_left(adc_left1), .adc_right(adc_right1), .adc_valid(adc_valid1),
    .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid), .dac_ready(dac_ready1),
    .dac_underrun_cnt(und1)
  );

  always @(posedge clk) begin
    if (adc_valid0) vc0 <= vc0 + 1;
    if (adc_valid1) vc1 <= vc1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit at slot position p for a word whose MSB sits at position 'first'.
  function automatic logic wbit(input logic [23:0] w, input int p, input int first,
                                input logic fill);
    logic [23:0] t;
    if (p >= first && p < first + 24) begin
      t = w << (p - first);
      return t[23];
    end
    return fill;
  endfunction

  function automatic logic [63:0] exp_dac(input logic [23:0] l, input logic [23:0] r,
                                          input int first);
    logic [63:0] e;
    e = '0;
    for (int p = 0; p < 32; p++) begin
      e[p]      = wbit(l, p, first, 1'b0);
      e[32 + p] = wbit(r, p, first, 1'b0);
    end
    return e;
  endfunction

  // One 32-bit slot; bclk half period is 5 clk. Optional same-cycle push at the LRCK edge
  // and optional reset pulse during bit rst_at.
  task automatic slot(input logic ch, input logic [23:0] aw, input logic coinc,
                      input int rst_at);
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      bclk = 1'b0;
      if (p == 0) lrck = ch;
      adcdat0 = wbit(aw, p, 1, 1'b1);
      adcdat1 = wbit(aw, p, 0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (coinc && p == 0 && k == 2) dac_valid = 1'b1;
        if (coinc && p == 0 && k == 3) dac_valid = 1'b0;
        if (rst_at == p && k == 1) reset = 1'b1;
        if (rst_at == p && k == 4) reset = 1'b0;
      end
      bclk = 1'b1;
      cap0[32*int'(ch) + p] = dacdat0;
      cap1[32*int'(ch) + p] = dacdat1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [23:0] al, input logic [23:0] ar, input logic coinc,
                       input int rst_at);
    slot(1'b0, al, coinc, -1);
    slot(1'b1, ar, 1'b0, rst_at);
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    dac_left  = l;
    dac_right = r;
    dac_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          ev;
    logic [23:0] el, er;
    al_t = '{24'h0, 24'hA5A5A5, 24'h123456, 24'h0F0F0F, 24'h800001, 24'hC3C3C3, 24'h000001,
             24'hFFFFFF, 24'h5A5A5A, 24'h246813, 24'h13579B, 24'hFEDCBA, 24'h111111,
             24'hABCDEF, 24'h999999, 24'h3C3C3C, 24'h777777};
    ar_t = '{24'h0, 24'h5A5A5A, 24'hFEDCBA, 24'hF0F0F0, 24'h7FFFFE, 24'h3C3C3C, 24'h800000,
             24'h000000, 24'hA5A5A5, 24'h135790, 24'h2468AC, 24'h012345, 24'hEEEEEE,
             24'hFEDCBA, 24'h666666, 24'hC3C3C3, 24'h888888};
    dl_t = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h800001, 24'h123456, 24'hFFFFFF, 24'hABCDEF,
             24'h0, 24'h13579B, 24'hAAAAAA, 24'h000080, 24'hC00003, 24'h0, 24'h0, 24'h0,
             24'h0};
    dr_t = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h7FFFFE, 24'h654321, 24'h000001, 24'hFEDCBA,
             24'h0, 24'h2468AC, 24'h555555, 24'h010000, 24'h3FFFFC, 24'h0, 24'h0, 24'h0,
             24'h0};

    reset     = 1'b1;
    bclk      = 1'b1;
    lrck      = 1'b1;
    adcdat0   = 1'b0;
    adcdat1   = 1'b0;
    dac_valid = 1'b0;
    dac_left  = '0;
    dac_right = '0;
    cap0      = '0;
    cap1      = '0;
    repeat (5) @(negedge clk);
    chk("rst_adc_left", adc_left0, 0);
    chk("rst_adc_right", adc_right0, 0);
    chk("rst_adc_valid", adc_valid0, 0);
    chk("rst_dac_ready0", dac_ready0, 0);
    chk("rst_dac_ready1", dac_ready1, 0);
    chk("rst_underrun", und0, 0);
    chk("rst_dacdat0", dacdat0, 0);
    chk("rst_dacdat1", dacdat1, 0);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst0", dac_ready0, 1);
    chk("ready_after_rst1", dac_ready1, 1);

    for (int n = 1; n <= 16; n++) begin
      if (n == 4) begin
        // Five back-to-back pushes into a depth-4 FIFO; the fifth is dropped.
        for (int i = 0; i < 4; i++) begin
          push(dl_t[4 + i], dr_t[4 + i]);
          chk($sformatf("ready_fill%0d", i), dac_ready0, (i < 3) ? 1 : 0);
        end
        push(24'hDEAD00, 24'h00BEEF);
        chk("ready_drop", dac_ready0, 0);
        chk("ready_drop1", dac_ready1, 0);
        @(negedge clk);
        dac_valid = 1'b0;
      end
      if (n == 9) begin
        for (int i = 0; i < 4; i++) begin
          push(dl_t[9 + i], dr_t[9 + i]);
          chk($sformatf("ready_refill%0d", i), dac_ready0, (i < 3) ? 1 : 0);
        end
        @(negedge clk);
        dac_valid = 1'b0;
        dac_left  = 24'h777777;
        dac_right = 24'h888888;
      end

      frame(al_t[n], ar_t[n], (n == 9), (n == 14) ? 10 : -1);

      if (n <= 13) begin
        chk($sformatf("dac_i2s_f%0d", n), cap0, exp_dac(dl_t[n], dr_t[n], 1));
        chk($sformatf("dac_lj_f%0d", n), cap1, exp_dac(dl_t[n], dr_t[n], 0));
      end
      if (n == 9) begin
        chk("ready_push_pop0", dac_ready0, 1);
        chk("ready_push_pop1", dac_ready1, 1);
      end

      ev = (n <= 14) ? n - 1 : n - 2;
      if (n == 1 || n == 14 || n == 15) begin
        el = '0;
        er = '0;
      end else begin
        el = al_t[n - 1];
        er = ar_t[n - 1];
      end
      chk($sformatf("adc_vcnt0_f%0d", n), vc0, ev);
      chk($sformatf("adc_vcnt1_f%0d", n), vc1, ev);
      chk($sformatf("adc_left0_f%0d", n), adc_left0, el);
      chk($sformatf("adc_right0_f%0d", n), adc_right0, er);
      chk($sformatf("adc_left1_f%0d", n), adc_left1, el);
      chk($sformatf("adc_right1_f%0d", n), adc_right1, er);

      if (n == 3) begin
        chk("underrun0_f3", und0, 3);
        chk("underrun1_f3", und1, 3);
      end
      if (n == 8)  chk("underrun0_f8", und0, 4);
      if (n == 13) chk("underrun0_f13", und0, 5);
      if (n == 16) begin
        chk("underrun0_f16", und0, 2);
        chk("underrun1_f16", und1, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
